midi_voice_ctrl: RTL and testbench
==================================

MIDI_VOICE_CTRL -- requirements
Module: midi_voice_ctrl

Interface
REQ-001 Parameter CHANNEL, default 0: MIDI channel (0-15) accepted; all other channels ignored.
REQ-002 Clk  input  1  single system clock; all logic rising-edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 midi_byte  input  8  received MIDI byte from the UART receiver.
REQ-005 midi_valid  input  1  midi_byte valid this cycle.
REQ-006 midi_ready  output  1  block can accept a byte; a byte is accepted when midi_valid && midi_ready.
REQ-007 F_out  output  24  phase increment for the voice NCOs.
REQ-008 A_out  output  16  oscillator amplitude.
REQ-009 key_on  output  1  gate to the voice envelope; level, not pulse.
REQ-010 loadF  output  1  one-cycle pulse when F_out updates.
REQ-011 loadA  output  1  one-cycle pulse when A_out updates.
REQ-012 note_out  output  7  currently sounding note number.

Function
REQ-013 Parser FSM states: IDLE, WAIT_D1, WAIT_D2, LOOKUP, EXEC.
REQ-014 Status byte 0x9n or 0x8n with n==CHANNEL, accepted in any state: store running status (on/off), go to WAIT_D1.
REQ-015 System real-time byte (0xF8-0xFF), accepted in any state: ignored, no state or running-status change.
REQ-016 Any other status byte (0x80-0xF7): clear running status, go to IDLE.
REQ-017 Data byte (bit 7 = 0) in IDLE: with valid running status, treat as note number and go to WAIT_D2; without it, discard.
REQ-018 Data byte in WAIT_D1: latch as note, go to WAIT_D2.
REQ-019 Data byte in WAIT_D2: latch as velocity, go to LOOKUP.
REQ-020 LOOKUP lasts one cycle while the ROM read completes, then EXEC.
REQ-021 EXEC lasts one cycle and updates outputs, then IDLE with running status retained.
REQ-022 midi_ready is low in LOOKUP and EXEC and high otherwise; a byte offered while midi_ready is low is dropped.
REQ-023 Note-on with velocity > 0: F_out = ROM[note], A_out per REQ-030/031, note_out = note, key_on = 1, loadF = loadA = 1. This applies even if a note is already sounding (monophonic, last-note priority).
REQ-024 Note-off, or note-on with velocity 0: if note == note_out and key_on = 1, key_on goes to 0, F_out, A_out and note_out hold, and no load pulse is issued; otherwise no output change.
REQ-025 Latency: the velocity byte is accepted at edge N; outputs and pulses are valid after edge N+2; loadF and loadA are deasserted after edge N+3.
REQ-026 Phase increment is defined as round(f_note * 2^24 / 48000), with f_note = 440 * 2^((note-69)/12); values are unsigned 24-bit.

Reset
REQ-027 While Reset is low: F_out = 0, A_out = 0, key_on = 0, loadF = 0, loadA = 0, note_out = 0, running status invalid, FSM in IDLE, midi_ready = 0.
REQ-028 Reset asserted mid-message aborts the message; the first byte after release is parsed from IDLE.
REQ-029 midi_ready rises in the first cycle after Reset deasserts.

Configuration
REQ-030 With macro MIDI_VELOCITY_EN defined: A_out = {1'b0, velocity[6:0], 8'h00}.
REQ-031 With MIDI_VELOCITY_EN undefined: A_out = 16'h7FFF on every note-on, and the velocity value is otherwise ignored except for the zero test in REQ-024.

Structure
REQ-032 The shared package synth_pkg holds PHASE_BITS = 24, SAMPLE_RATE = 48000, the MIDI status constants (0x80, 0x90, 0xF8) and the parser state enum.
REQ-033 Sub-module midi_note_rom: 128 x 24 synchronous-read ROM, address = note, one-cycle read latency, contents per REQ-026.

Verification
REQ-034 0x90, 0x45, 0x64 (CHANNEL 0) -> 2 cycles after the last byte: F_out = 0x0258BF, key_on = 1, note_out = 69, one-cycle loadF/loadA pulses; A_out = 0x6400 with the macro, 0x7FFF without.
REQ-035 After REQ-034, running status 0x45, 0x00 -> key_on = 0, F_out holds 0x0258BF, no load pulse.
REQ-036 0x90, 0x3C, 0x7F then 0x80, 0x45, 0x40 -> key_on stays 1 and note_out stays 60 (non-matching note-off ignored).
REQ-037 0x91, 0x45, 0x64 with CHANNEL = 0 -> no output change, no pulses; 0x90, 0x45, 0xF8, 0x64 -> identical result to REQ-034.
REQ-038 Reset driven low after 0x90, 0x45 -> all outputs 0; after release, 0x64 alone -> discarded, no output change.
REQ-039 A byte offered in the LOOKUP cycle -> midi_ready = 0, the byte is dropped, and the FSM is unaffected.

Source files
------------

// File: rtl/synth_pkg.sv
// ============================================================================
// Module : synth_pkg
// Shared synthesiser constants, MIDI status codes and parser state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package synth_pkg;

  localparam int PHASE_BITS  = 24;
  localparam int SAMPLE_RATE = 48000;

  localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;
  localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
  localparam logic [7:0] MIDI_RT_MIN   = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_D1 = 3'd1,
    ST_WAIT_D2 = 3'd2,
    ST_LOOKUP  = 3'd3,
    ST_EXEC    = 3'd4
  } parse_state_e;

  // System real-time bytes may interleave anywhere without disturbing parsing.
  function automatic logic is_realtime(input logic [7:0] b);
    return (b >= MIDI_RT_MIN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/midi_note_rom.sv
// ============================================================================
// Module : midi_note_rom
// 128 x 24 synchronous-read table of NCO phase increments, indexed by note.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module midi_note_rom
  import synth_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [6:0]            addr_i,
  output logic [PHASE_BITS-1:0] data_o
);

  logic [PHASE_BITS-1:0] rom_w [128];
  logic [PHASE_BITS-1:0] data_q;

  // Contents are elaboration-time constants: equal-tempered pitch, A4 = 440 Hz.
  for (genvar i = 0; i < 128; i++) begin : g_rom
    localparam real c_freq = 440.0 * (2.0 ** (real'(i - 69) / 12.0));
    localparam logic [31:0] c_inc =
      $rtoi(c_freq * real'(32'd1 << PHASE_BITS) / real'(SAMPLE_RATE) + 0.5);
    assign rom_w[i] = c_inc[PHASE_BITS-1:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      data_q <= '0;
    end else begin
      data_q <= rom_w[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/midi_voice_ctrl.sv
// ============================================================================
// Module : midi_voice_ctrl
// Monophonic MIDI note-on/off parser driving one NCO voice (last-note priority).
// Option : define MIDI_VELOCITY_EN to scale A_out by note-on velocity.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module midi_voice_ctrl
  import synth_pkg::*;
#(
  parameter int CHANNEL = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [7:0]            midi_byte,
  input  logic                  midi_valid,
  output logic                  midi_ready,
  output logic [PHASE_BITS-1:0] F_out,
  output logic [15:0]           A_out,
  output logic                  key_on,
  output logic                  loadF,
  output logic                  loadA,
  output logic [6:0]            note_out
);

  localparam logic [3:0] CH = CHANNEL[3:0];

  parse_state_e          state_q, state_d;
  logic                  rs_valid_q, rs_valid_d;
  logic                  rs_on_q, rs_on_d;
  logic [6:0]            note_q, note_d;
  logic [6:0]            vel_q, vel_d;
  logic                  en_q;
  logic [PHASE_BITS-1:0] f_q, f_d;
  logic [15:0]           a_q, a_d;
  logic                  key_q, key_d;
  logic                  loadf_q, loadf_d;
  logic                  loada_q, loada_d;
  logic [6:0]            nout_q, nout_d;

  logic [PHASE_BITS-1:0] rom_data_w;
  logic [15:0]           amp_w;
  logic                  accept_w;
  logic                  voice_status_w;

  midi_note_rom u_rom (
    .Clk    (Clk),
    .Reset  (Reset),
    .addr_i (note_q),
    .data_o (rom_data_w)
  );

`ifdef MIDI_VELOCITY_EN
  assign amp_w = {1'b0, vel_q, 8'h00};
`else
  assign amp_w = 16'h7FFF;
`endif

  assign midi_ready     = en_q && (state_q != ST_LOOKUP) && (state_q != ST_EXEC);
  assign accept_w       = midi_valid && midi_ready;
  assign voice_status_w = ((midi_byte[7:4] == MIDI_NOTE_ON[7:4]) ||
                           (midi_byte[7:4] == MIDI_NOTE_OFF[7:4])) &&
                          (midi_byte[3:0] == CH);

  always_comb begin
    state_d    = state_q;
    rs_valid_d = rs_valid_q;
    rs_on_d    = rs_on_q;
    note_d     = note_q;
    vel_d      = vel_q;
    f_d        = f_q;
    a_d        = a_q;
    key_d      = key_q;
    nout_d     = nout_q;
    loadf_d    = 1'b0;
    loada_d    = 1'b0;

    case (state_q)
      ST_LOOKUP: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (rs_on_q && (vel_q != 7'd0)) begin
          f_d     = rom_data_w;
          a_d     = amp_w;
          nout_d  = note_q;
          key_d   = 1'b1;
          loadf_d = 1'b1;
          loada_d = 1'b1;
        end else if ((note_q == nout_q) && key_q) begin
          key_d = 1'b0;
        end
      end
      default: begin
        if (accept_w) begin
          if (midi_byte[7]) begin
            if (is_realtime(midi_byte)) begin
              state_d = state_q;
            end else if (voice_status_w) begin
              rs_valid_d = 1'b1;
              rs_on_d    = midi_byte[4];
              state_d    = ST_WAIT_D1;
            end else begin
              rs_valid_d = 1'b0;
              state_d    = ST_IDLE;
            end
          end else begin
            case (state_q)
              ST_IDLE: begin
                if (rs_valid_q) begin
                  note_d  = midi_byte[6:0];
                  state_d = ST_WAIT_D2;
                end
              end
              ST_WAIT_D1: begin
                note_d  = midi_byte[6:0];
                state_d = ST_WAIT_D2;
              end
              ST_WAIT_D2: begin
                vel_d   = midi_byte[6:0];
                state_d = ST_LOOKUP;
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      rs_valid_q <= 1'b0;
      rs_on_q    <= 1'b0;
      note_q     <= '0;
      vel_q      <= '0;
      en_q       <= 1'b0;
      f_q        <= '0;
      a_q        <= '0;
      key_q      <= 1'b0;
      loadf_q    <= 1'b0;
      loada_q    <= 1'b0;
      nout_q     <= '0;
    end else begin
      state_q    <= state_d;
      rs_valid_q <= rs_valid_d;
      rs_on_q    <= rs_on_d;
      note_q     <= note_d;
      vel_q      <= vel_d;
      en_q       <= 1'b1;
      f_q        <= f_d;
      a_q        <= a_d;
      key_q      <= key_d;
      loadf_q    <= loadf_d;
      loada_q    <= loada_d;
      nout_q     <= nout_d;
    end
  end

  assign F_out    = f_q;
  assign A_out    = a_q;
  assign key_on   = key_q;
  assign loadF    = loadf_q;
  assign loadA    = loada_q;
  assign note_out = nout_q;

endmodule

`default_nettype wire

// File: tb/tb_midi_voice_ctrl.sv
// ============================================================================
// Module : tb_midi_voice_ctrl
// Self-checking bench for midi_voice_ctrl: message-level model plus pinned values.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_midi_voice_ctrl;

`ifdef MIDI_VELOCITY_EN
  localparam logic [15:0] A_REQ034 = 16'h6400;
  localparam logic [15:0] A_VEL1   = 16'h0100;
`else
  localparam logic [15:0] A_REQ034 = 16'h7FFF;
  localparam logic [15:0] A_VEL1   = 16'h7FFF;
`endif

  logic        Clk;
  logic        Reset;
  logic [7:0]  midi_byte;
  logic        midi_valid;
  logic        midi_ready;
  logic [23:0] F_out;
  logic [15:0] A_out;
  logic        key_on;
  logic        loadF;
  logic        loadA;
  logic [6:0]  note_out;

  midi_voice_ctrl #(.CHANNEL(0)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .midi_byte  (midi_byte),
    .midi_valid (midi_valid),
    .midi_ready (midi_ready),
    .F_out      (F_out),
    .A_out      (A_out),
    .key_on     (key_on),
    .loadF      (loadF),
    .loadA      (loadA),
    .note_out   (note_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference pitch table computed straight from the tuning formula.
  function automatic logic [23:0] phase_inc(input int n);
    real f;
    f = 440.0 * (2.0 ** ((n - 69) / 12.0));
    return 24'($rtoi(f * 16777216.0 / 48000.0 + 0.5));
  endfunction

  function automatic logic [15:0] amp_of(input logic [6:0] v);
`ifdef MIDI_VELOCITY_EN
    return {1'b0, v, 8'h00};
`else
    return (v == 7'd0) ? 16'h0000 : 16'h7FFF;
`endif
  endfunction

  // Message-level model: running status kind, collected data bytes, pending exec.
  logic [23:0] m_F;
  logic [15:0] m_A;
  logic        m_key, m_ldF, m_ldA, m_ready;
  logic [6:0]  m_note;
  int          rs;      // 0 none, 1 note-on, 2 note-off
  int          ncol;
  int          cnt;
  logic [6:0]  mn_note, mn_vel;
  logic        mn_on;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_F = '0; m_A = '0; m_key = 1'b0; m_note = '0;
      m_ldF = 1'b0; m_ldA = 1'b0; m_ready = 1'b0;
      rs = 0; ncol = 0; cnt = 0;
    end else begin
      logic       acc;
      logic [7:0] b;
      acc   = midi_valid && m_ready;
      b     = midi_byte;
      m_ldF = 1'b0;
      m_ldA = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          if (mn_on && mn_vel != 7'd0) begin
            m_F = phase_inc(int'(mn_note));
            m_A = amp_of(mn_vel);
            m_note = mn_note;
            m_key = 1'b1; m_ldF = 1'b1; m_ldA = 1'b1;
          end else if (mn_note == m_note && m_key) begin
            m_key = 1'b0;
          end
        end
      end
      if (acc) begin
        if (b[7]) begin
          if (b >= 8'hF8) begin
            rs = rs;
          end else if ((b[7:4] == 4'h9 || b[7:4] == 4'h8) && b[3:0] == 4'd0) begin
            rs = b[4] ? 1 : 2; ncol = 0;
          end else begin
            rs = 0; ncol = 0;
          end
        end else if (rs != 0) begin
          if (ncol == 0) begin
            mn_note = b[6:0]; ncol = 1;
          end else begin
            mn_vel = b[6:0]; mn_on = (rs == 1); ncol = 0; cnt = 2;
          end
        end
      end
      m_ready = (cnt == 0);
    end
  end

  // Hand-computed expectations requested by the stimulus, checked at the next falling edge.
  int          pin_req = 0;
  int          pin_done = 0;
  logic [5:0]  pin_mask;
  logic [23:0] pin_F;
  logic [15:0] pin_A;
  logic        pin_key, pin_ld, pin_rdy;
  logic [6:0]  pin_note;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    cmp("model_ready",  32'(midi_ready), 32'(m_ready));
    cmp("model_F_out",  32'(F_out),      32'(m_F));
    cmp("model_A_out",  32'(A_out),      32'(m_A));
    cmp("model_key_on", 32'(key_on),     32'(m_key));
    cmp("model_note",   32'(note_out),   32'(m_note));
    cmp("model_loadF",  32'(loadF),      32'(m_ldF));
    cmp("model_loadA",  32'(loadA),      32'(m_ldA));
    if (pin_req != pin_done) begin
      pin_done = pin_req;
      if (pin_mask[0]) cmp("pin_F_out",  32'(F_out),    32'(pin_F));
      if (pin_mask[1]) cmp("pin_A_out",  32'(A_out),    32'(pin_A));
      if (pin_mask[2]) cmp("pin_key_on", 32'(key_on),   32'(pin_key));
      if (pin_mask[3]) cmp("pin_note",   32'(note_out), 32'(pin_note));
      if (pin_mask[4]) cmp("pin_loadF",  32'(loadF),    32'(pin_ld));
      if (pin_mask[4]) cmp("pin_loadA",  32'(loadA),    32'(pin_ld));
      if (pin_mask[5]) cmp("pin_ready",  32'(midi_ready), 32'(pin_rdy));
    end
  end

  task automatic pin(input logic [5:0] mask, input logic [23:0] f, input logic [15:0] a,
                     input logic key, input logic [6:0] note, input logic ld, input logic rdy);
    pin_mask = mask; pin_F = f; pin_A = a; pin_key = key;
    pin_note = note; pin_ld = ld; pin_rdy = rdy;
    pin_req++;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    midi_byte  = b;
    midi_valid = 1'b1;
    tick();
    midi_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; midi_valid = 1'b0; midi_byte = 8'h00;
    repeat (3) tick();
    pin(6'h3F, 24'h0, 16'h0, 1'b0, 7'd0, 1'b0, 1'b0);
    tick();
    Reset = 1'b1;
    tick();
    pin(6'h20, 24'h0, 16'h0, 1'b0, 7'd0, 1'b0, 1'b1);
    tick();

    // Basic note-on, A4
    send(8'h90); send(8'h45); send(8'h64);
    tick(); tick();
    pin(6'h1F, 24'h0258BF, A_REQ034, 1'b1, 7'd69, 1'b1, 1'b0);
    tick();
    pin(6'h10, 24'h0, 16'h0, 1'b0, 7'd0, 1'b0, 1'b0);
    tick();

    // Running-status note-on velocity 0 releases the key
    send(8'h45); send(8'h00);
    tick(); tick();
    pin(6'h1D, 24'h0258BF, 16'h0, 1'b0, 7'd69, 1'b0, 1'b0);
    tick();

    // Non-matching note-off is ignored
    send(8'h90); send(8'h3C); send(8'h7F);
    tick(); tick();
    pin(6'h1D, 24'h016535, 16'h0, 1'b1, 7'd60, 1'b1, 1'b0);
    tick();
    send(8'h80); send(8'h45); send(8'h40);
    tick(); tick();
    pin(6'h1D, 24'h016535, 16'h0, 1'b1, 7'd60, 1'b0, 1'b0);
    tick();

    // Other channel ignored; real-time byte mid-message transparent
    send(8'h91); send(8'h45); send(8'h64);
    tick(); tick();
    pin(6'h1D, 24'h016535, 16'h0, 1'b1, 7'd60, 1'b0, 1'b0);
    tick();
    send(8'h90); send(8'h45); send(8'hF8); send(8'h64);
    tick(); tick();
    pin(6'h1F, 24'h0258BF, A_REQ034, 1'b1, 7'd69, 1'b1, 1'b0);
    tick();

    // Byte offered in the LOOKUP cycle is dropped
    send(8'h90); send(8'h3C); send(8'h50);
    midi_byte = 8'h3E; midi_valid = 1'b1;
    pin(6'h20, 24'h0, 16'h0, 1'b0, 7'd0, 1'b0, 1'b0);
    tick();
    midi_valid = 1'b0;
    tick();
    pin(6'h1D, 24'h016535, 16'h0, 1'b1, 7'd60, 1'b1, 1'b0);
    tick();
    send(8'h40); send(8'h30);
    tick(); tick();
    pin(6'h1C, 24'h0, 16'h0, 1'b1, 7'd64, 1'b1, 1'b0);
    tick();

    // Unrelated status clears running status; data bytes then discarded
    send(8'hB0); send(8'h45); send(8'h64);
    tick(); tick();
    pin(6'h1C, 24'h0, 16'h0, 1'b1, 7'd64, 1'b0, 1'b0);
    tick();
    send(8'h80); send(8'h40); send(8'h00);
    tick(); tick();
    pin(6'h1C, 24'h0, 16'h0, 1'b0, 7'd64, 1'b0, 1'b0);
    tick();

    // Table extremes
    send(8'h90); send(8'h00); send(8'h01);
    tick(); tick();
    pin(6'h1F, 24'd2858, A_VEL1, 1'b1, 7'd0, 1'b1, 1'b0);
    tick();
    send(8'h7F); send(8'h7F);
    tick(); tick();
    pin(6'h1D, 24'd4384395, 16'h0, 1'b1, 7'd127, 1'b1, 1'b0);
    tick();

    // Reset mid-message, then an orphan data byte
    send(8'h90); send(8'h45);
    Reset = 1'b0;
    pin(6'h3F, 24'h0, 16'h0, 1'b0, 7'd0, 1'b0, 1'b0);
    tick();
    Reset = 1'b1;
    tick();
    send(8'h64);
    tick(); tick();
    pin(6'h3D, 24'h0, 16'h0, 1'b0, 7'd0, 1'b0, 1'b1);
    tick(); tick();

    @(negedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
